polar_to_cartesian: RTL and testbench
=====================================

# polar_to_cartesian

Pipelined CORDIC in rotation mode. It converts a stream of `{magnitude, phase}` samples to `{q, i}` cartesian samples, and is the inverse companion of `cartesian_to_polar`. Both blocks use the same phase scaling, the same packing convention and the same valid/ready stream handshake. It sits in the transmit and correction paths, for example NCO generation and phase de-rotation, and accepts one sample per cycle.

## Interface
- `WIDTH`, default 32: signed width of each half of the input and output words.
- `DEPTH`, default 16: number of CORDIC micro-rotation stages.

Ports:
- `clk`  in  1: single clock.
- `reset`  in  1: synchronous, active-high.
- `s_valid`  in  1: input sample valid.
- `s_ready`  out  1: input sample accepted when `s_valid && s_ready` at a rising edge.
- `s_data`  in  2*WIDTH: `[2*WIDTH-1:WIDTH]` is the signed magnitude; `[WIDTH-1:0]` is the signed phase, where 2^(WIDTH-1) represents pi.
- `m_valid`  out  1: output sample valid.
- `m_ready`  in  1: downstream accepts.
- `m_data`  out  2*WIDTH: `[2*WIDTH-1:WIDTH]` is signed q; `[WIDTH-1:0]` is signed i.

## Operation
**Internal types**
- x and y are WIDTH+2-bit signed values.
- z (residual phase) is a WIDTH-bit signed value that wraps naturally.

**Stage 0: pre-rotation on phase bits `[WIDTH-1:WIDTH-2]`**
- `00` or `11`: x=mag, y=0, z=phase.
- `01`: x=0, y=mag, z=phase−PI_2.
- `10`: x=0, y=−mag, z=phase+PI_2.
- PI_2 = 2^(WIDTH-2).

**Stage n, for n = 1..DEPTH, with k = n−1**
- If z ≥ 0: x −= y>>>k, y += x>>>k, z −= atan_lut[k].
- If z < 0: x += y>>>k, y −= x>>>k, z += atan_lut[k].
- The right-hand sides use the previous stage's values.
- Shifts are arithmetic.
- atan_lut[k] = atan(2^-k)·2^(WIDTH-1)/pi, truncated toward zero, computed at elaboration.

**Gain and output**
- There is no gain compensation. The output equals K·mag·(cos, sin), with K ≈ 1.6468 for DEPTH ≥ 8. This matches the uncompensated magnitude of `cartesian_to_polar`.
- The output is saturated from WIDTH+2 bits to [−2^(WIDTH-1), 2^(WIDTH-1)−1] independently on i and q. This is combinational from the last stage.
- A negative magnitude is legal and yields the negated vector.

## Timing
**Handshake and advance**
- Advance enable: `adv = !m_valid || m_ready`.
- `s_ready = adv`, combinational.
- All data stages and the valid shift register update only when `adv` is high.
- Stage 0 captures input when `s_valid && s_ready`. Otherwise it captures a bubble (valid bit 0).

**Latency and throughput**
- A sample accepted at edge E0 sets `m_valid` at edge E_DEPTH, giving a latency of DEPTH cycles without stalls.
- Throughput is 1 sample per cycle.

**Backpressure**
- While `m_valid && !m_ready`, the whole pipeline freezes.
- `m_data` and `m_valid` hold stable.
- `s_ready` is 0, so no sample is lost or reordered.

**Reset**
- The valid shift register and `m_valid` clear to 0 on the next edge.
- Data registers are not reset; their contents are don't-care while invalid.
- `s_ready` reads 1 after reset.
- Any input presented in a cycle with `reset` high is discarded.
- Reset mid-stream drops all in-flight samples. No stale output appears afterwards.

**Simultaneous events**
- `m_ready` with `s_valid` in the same cycle: the output is consumed and the new input is accepted on the same edge.

## Structure
**Package `cordic_pkg`** holds:
- the `data_t` and `wide_t` typedef pattern;
- the PI_2 constant function;
- the `atan_lut` generation function, shared with `cartesian_to_polar`;
- the saturate function.

**Sub-module `cordic_rotate_stage`** is one micro-rotation register stage.
- Parameters: WIDTH, SHIFT, ATAN.
- Inputs: x, y, z, `adv`. Outputs: registered x, y, z.
- It is instantiated DEPTH times via generate.

## Test plan
All scenarios use WIDTH=16 and DEPTH=16, so pi = 32768. Tolerance is ±16 LSB per component unless stated.

- mag=10000, phase=0 → i≈16468, q≈0. `m_valid` rises exactly 16 edges after acceptance.
- mag=10000, phase=16384 → i≈0, q≈16468. phase=−32768 → i≈−16468, q≈0. phase=8192 → i≈q≈11645.
- mag=32767, phase=0 → i saturates to 32767, q≈0. phase=−32768 → i saturates to −32768.
- Burst of 20 samples with random `m_ready` backpressure, including holding `m_ready` low for 5 cycles with `m_valid` high → `m_data` stable while stalled, all 20 outputs delivered in order and matching the model.
- Assert `reset` for one cycle with 8 samples in flight → `m_valid` is 0 after the edge and no output appears until new input is accepted.
- Round trip through `cartesian_to_polar`, then this block, with random (i, q) at ≤ 1/4 full scale → output ≈ K²·(i, q), with K² ≈ 2.712, within ±32 LSB.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC helpers: phase constants, elaboration-time arctangent table and
// output saturation, used by both polar_to_cartesian and cartesian_to_polar.
package cordic_pkg;

  localparam int MAX_W = 64;
  typedef logic signed [MAX_W-1:0] wide_t;

  // pi scaled by 2^60, the fixed-point base of the arctangent series below
  localparam logic [127:0] PI_FX = 128'd3622009729038561421;

  function automatic logic [63:0] pi_2(input int width);
    return 64'd1 << (width - 2);
  endfunction

  // atan(2^-k) * 2^(width-1) / pi, truncated; Taylor series in 60-bit fixed point
  function automatic logic [63:0] atan_lut(input int k, input int width);
    logic [127:0] acc, term;
    int sh;
    if (k == 0) return 64'd1 << (width - 3);
    acc = '0;
    for (int j = 0; j < 32; j++) begin
      sh = 60 - k * (2 * j + 1);
      if (sh >= 0) begin
        term = (128'd1 << sh) / 128'(2 * j + 1);
        acc  = (j % 2 == 0) ? acc + term : acc - term;
      end
    end
    acc = (acc << (width - 1)) / PI_FX;
    return 64'(acc);
  endfunction

  function automatic wide_t saturate(input wide_t v, input int width);
    wide_t hi, lo;
    hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (width - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cordic_rotate_stage.sv
// One CORDIC rotation-mode micro-rotation, registered; holds while adv is low.
module cordic_rotate_stage #(
  parameter int               WIDTH = 32,
  parameter int               SHIFT = 0,
  parameter logic [WIDTH-1:0] ATAN  = '0
) (
  input  logic                   clk,
  input  logic                   adv,
  input  logic signed [WIDTH+1:0] x_i,
  input  logic signed [WIDTH+1:0] y_i,
  input  logic signed [WIDTH-1:0] z_i,
  output logic signed [WIDTH+1:0] x_o,
  output logic signed [WIDTH+1:0] y_o,
  output logic signed [WIDTH-1:0] z_o
);

  logic signed [WIDTH+1:0] x_d, y_d, x_q, y_q;
  logic signed [WIDTH-1:0] z_d, z_q;

  always_comb begin
    if (!z_i[WIDTH-1]) begin
      x_d = x_i - (y_i >>> SHIFT);
      y_d = y_i + (x_i >>> SHIFT);
      z_d = z_i - ATAN;
    end else begin
      x_d = x_i + (y_i >>> SHIFT);
      y_d = y_i - (x_i >>> SHIFT);
      z_d = z_i + ATAN;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;
  assign z_o = z_q;

endmodule

// File: rtl/polar_to_cartesian.sv
// Pipelined rotation-mode CORDIC: {magnitude, phase} -> {q, i}, uncompensated gain,
// valid/ready stream with whole-pipeline freeze on backpressure.
module polar_to_cartesian
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [2*WIDTH-1:0]   s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [2*WIDTH-1:0]   m_data
);

  typedef logic signed [WIDTH-1:0] data_t;
  typedef logic signed [WIDTH+1:0] xy_t;

  localparam data_t PI_2 = data_t'(pi_2(WIDTH));

  logic                        adv;
  logic [DEPTH:0]              vld_pipe_q;
  logic [DEPTH:0][WIDTH+1:0]   x_s, y_s;
  logic [DEPTH:0][WIDTH-1:0]   z_s;

  data_t mag, phase, z0_d, z0_q;
  xy_t   mag_x, x0_d, y0_d, x0_q, y0_q;

  assign adv     = !m_valid || m_ready;
  assign s_ready = adv;
  assign m_valid = vld_pipe_q[DEPTH];

  assign mag   = s_data[2*WIDTH-1:WIDTH];
  assign phase = s_data[WIDTH-1:0];
  assign mag_x = xy_t'(mag);

  // Quadrant pre-rotation brings the residual phase into [-pi/2, pi/2)
  always_comb begin
    x0_d = '0;
    y0_d = '0;
    z0_d = phase;
    unique case (phase[WIDTH-1 -: 2])
      2'b01:   begin y0_d = mag_x;  z0_d = phase - PI_2; end
      2'b10:   begin y0_d = -mag_x; z0_d = phase + PI_2; end
      default: x0_d = mag_x;
    endcase
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      x0_q <= x0_d;
      y0_q <= y0_d;
      z0_q <= z0_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)    vld_pipe_q <= '0;
    else if (adv) vld_pipe_q <= {vld_pipe_q[DEPTH-1:0], s_valid};
  end

  assign x_s[0] = x0_q;
  assign y_s[0] = y0_q;
  assign z_s[0] = z0_q;

  for (genvar n = 1; n <= DEPTH; n++) begin : g_stage
    cordic_rotate_stage #(
      .WIDTH (WIDTH),
      .SHIFT (n - 1),
      .ATAN  (WIDTH'(atan_lut(n - 1, WIDTH)))
    ) u_stage (
      .clk (clk),
      .adv (adv),
      .x_i (x_s[n-1]),
      .y_i (y_s[n-1]),
      .z_i (z_s[n-1]),
      .x_o (x_s[n]),
      .y_o (y_s[n]),
      .z_o (z_s[n])
    );
  end

  assign m_data = {WIDTH'(saturate(wide_t'(signed'(y_s[DEPTH])), WIDTH)),
                   WIDTH'(saturate(wide_t'(signed'(x_s[DEPTH])), WIDTH))};

  // Residual phase of the last stage is not needed downstream
  logic unused_z;
  assign unused_z = ^z_s[DEPTH];

endmodule

// File: tb/tb_polar_to_cartesian.sv
// Randomised self-checking bench for polar_to_cartesian against a trigonometric model.
module tb_polar_to_cartesian;

  localparam int    W   = 16;
  localparam int    D   = 16;
  localparam int    TOL = 16;
  localparam real   PI  = 3.14159265358979323846;

  logic            clk = 1'b0;
  logic            reset, s_valid, s_ready, m_valid, m_ready;
  logic [2*W-1:0]  s_data, m_data;
  int              n_chk = 0, n_fail = 0;
  real             K;

  always #5 clk = ~clk;

  polar_to_cartesian #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  function automatic int rnd_sat(input real v);
    int r;
    r = $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  // Ideal output: K * mag * (cos, sin) of the scaled phase, saturated
  task automatic model(input int mag, input int ph, output int ei, output int eq);
    real a;
    a  = real'(ph) * PI / 32768.0;
    ei = rnd_sat(K * real'(mag) * $cos(a));
    eq = rnd_sat(K * real'(mag) * $sin(a));
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int out_i();
    logic signed [W-1:0] v;
    v = m_data[W-1:0];
    return int'(v);
  endfunction

  function automatic int out_q();
    logic signed [W-1:0] v;
    v = m_data[2*W-1:W];
    return int'(v);
  endfunction

  // Drives one sample into an idle pipeline and waits for its result
  task automatic send_one(input int mag, input int ph, output int lat, output int oi, output int oq);
    s_valid = 1'b1; s_data = {16'(mag), 16'(ph)}; m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; lat = -1; oi = 0; oq = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (m_valid && lat < 0) begin lat = n; oi = out_i(); oq = out_q(); end
    end
  endtask

  task automatic test_reset();
    bit seen;
    reset = 1'b1; m_ready = 1'b0; s_valid = 1'b1; s_data = $urandom;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    n_chk++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
    reset = 1'b0; s_valid = 1'b0; seen = 0;
    repeat (20) begin @(posedge clk); #1; if (m_valid) seen = 1; end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_discard: output seen %b expected 0", seen); end
  endtask

  task automatic test_directed();
    int mags[8] = '{10000, 10000, 10000, 10000, -10000, 7000, 5000, 10000};
    int phs[8]  = '{0, 16384, -32768, 8192, 3000, -12000, 24000, -20000};
    int lat, oi, oq, ei, eq;
    for (int t = 0; t < 8; t++) begin
      if (t >= 5) begin mags[t] = $urandom_range(0, 16000) - 8000; phs[t] = $urandom_range(0, 65535) - 32768; end
      model(mags[t], phs[t], ei, eq);
      send_one(mags[t], phs[t], lat, oi, oq);
      n_chk++; if (lat !== D) begin n_fail++; $display("FAIL latency[%0d]: got %0d expected %0d", t, lat, D); end
      n_chk++; if (iabs(oi - ei) > TOL) begin n_fail++; $display("FAIL dir_i[%0d]: got %0d expected %0d", t, oi, ei); end
      n_chk++; if (iabs(oq - eq) > TOL) begin n_fail++; $display("FAIL dir_q[%0d]: got %0d expected %0d", t, oq, eq); end
    end
  endtask

  task automatic test_saturation();
    int mags[3] = '{32767, 32767, -32768};
    int phs[3]  = '{0, -32768, 0};
    int lat, oi, oq, ei, eq;
    for (int t = 0; t < 3; t++) begin
      model(mags[t], phs[t], ei, eq);
      send_one(mags[t], phs[t], lat, oi, oq);
      n_chk++; if (oi !== ei) begin n_fail++; $display("FAIL sat_i[%0d]: got %0d expected %0d", t, oi, ei); end
      n_chk++; if (iabs(oq - eq) > TOL) begin n_fail++; $display("FAIL sat_q[%0d]: got %0d expected %0d", t, oq, eq); end
    end
  endtask

  task automatic test_backpressure();
    int exp_i[$], exp_q[$];
    int sent = 0, got = 0, cyc = 0, hold = 0, cur_m = 0, cur_p = 0, ei, eq, oi, oq;
    bit have = 0, forced = 0, stall_q = 0, acc_in, acc_out;
    logic [2*W-1:0] data_q = '0;
    while (got < 20 && cyc < 2000) begin
      if (sent < 20) begin
        if (!have) begin
          cur_m = $urandom_range(0, 12000) - 6000; cur_p = $urandom_range(0, 65535) - 32768; have = 1;
        end
        s_valid = 1'b1; s_data = {16'(cur_m), 16'(cur_p)};
      end else s_valid = 1'b0;
      if (hold > 0) begin m_ready = 1'b0; hold--; end else m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stall_q) begin
        n_chk++;
        if (m_valid !== 1'b1 || m_data !== data_q) begin
          n_fail++; $display("FAIL stall_hold: got v=%b d=%h expected v=1 d=%h", m_valid, m_data, data_q);
        end
      end
      acc_in  = s_valid && s_ready;
      acc_out = m_valid && m_ready;
      stall_q = m_valid && !m_ready;
      data_q  = m_data;
      if (acc_out) begin
        oi = out_i(); oq = out_q();
        n_chk++;
        if (exp_i.size() == 0) begin n_fail++; $display("FAIL bp_extra: output %0d with none pending", got); end
        else begin
          ei = exp_i.pop_front(); eq = exp_q.pop_front();
          if (iabs(oi - ei) > TOL || iabs(oq - eq) > TOL) begin
            n_fail++; $display("FAIL bp_data[%0d]: got (%0d,%0d) expected (%0d,%0d)", got, oi, oq, ei, eq);
          end
        end
        got++;
        if (!forced && got == 5) begin forced = 1; hold = 5; end
      end
      if (acc_in) begin model(cur_m, cur_p, ei, eq); exp_i.push_back(ei); exp_q.push_back(eq); sent++; have = 0; end
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0; m_ready = 1'b1;
    n_chk++; if (got !== 20) begin n_fail++; $display("FAIL bp_count: got %0d outputs expected 20", got); end
  endtask

  task automatic test_reset_midstream();
    int lat, oi, oq, ei, eq, m, p;
    bit seen = 0;
    m_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      s_valid = 1'b1; s_data = {16'($urandom_range(0, 8000)), 16'($urandom)};
      @(posedge clk); #1;
    end
    reset = 1'b1; s_data = $urandom;
    @(posedge clk); #1;
    reset = 1'b0; s_valid = 1'b0;
    n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", m_valid); end
    repeat (30) begin @(posedge clk); #1; if (m_valid) seen = 1; end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stale: output seen %b expected 0", seen); end
    m = 9000; p = -5000;
    model(m, p, ei, eq);
    send_one(m, p, lat, oi, oq);
    n_chk++; if (lat !== D) begin n_fail++; $display("FAIL rst_mid_latency: got %0d expected %0d", lat, D); end
    n_chk++;
    if (iabs(oi - ei) > TOL || iabs(oq - eq) > TOL) begin
      n_fail++; $display("FAIL rst_mid_data: got (%0d,%0d) expected (%0d,%0d)", oi, oq, ei, eq);
    end
  endtask

  // Polar inputs as the uncompensated cartesian_to_polar would produce them
  task automatic test_back_to_back();
    localparam int N = 24;
    int exp_i[$], exp_q[$];
    int ci, cq, mag, ph, oi, oq, ei, eq, got = 0;
    m_ready = 1'b1;
    for (int c = 0; c < N + D + 4; c++) begin
      if (c < N) begin
        ci  = $urandom_range(0, 16384) - 8192; cq = $urandom_range(0, 16384) - 8192;
        mag = $rtoi(K * $sqrt(real'(ci) * ci + real'(cq) * cq) + 0.5);
        ph  = rnd_sat(0.0) + $rtoi($floor($atan2(real'(cq), real'(ci)) * 32768.0 / PI + 0.5));
        s_valid = 1'b1; s_data = {16'(mag), 16'(ph)};
        exp_i.push_back(rnd_sat(K * K * ci)); exp_q.push_back(rnd_sat(K * K * cq));
      end else s_valid = 1'b0;
      @(negedge clk);
      if (m_valid && exp_i.size() > 0) begin
        oi = out_i(); oq = out_q(); ei = exp_i.pop_front(); eq = exp_q.pop_front();
        n_chk++;
        if (iabs(oi - ei) > 2 * TOL || iabs(oq - eq) > 2 * TOL) begin
          n_fail++; $display("FAIL roundtrip[%0d]: got (%0d,%0d) expected (%0d,%0d)", got, oi, oq, ei, eq);
        end
        got++;
      end
      @(posedge clk); #1;
    end
    n_chk++; if (got !== N) begin n_fail++; $display("FAIL roundtrip_count: got %0d expected %0d", got, N); end
  endtask

  initial begin
    K = 1.0;
    for (int k = 0; k < D; k++) K = K * $sqrt(1.0 + 1.0 / (4.0 ** k));
    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    test_reset();
    test_directed();
    test_saturation();
    test_backpressure();
    test_reset_midstream();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
